// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM states, BCD digit type,
// and a helper that increments a packed 4-digit BCD value with decimal carry.
package stopwatch_pkg;

  localparam int BCD_MAX = 9;
  localparam int COUNT_W = 16;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  function automatic logic [COUNT_W-1:0] bcd_inc(input logic [COUNT_W-1:0] v);
    logic [COUNT_W-1:0] r;
    logic               carry;
    bcd_digit_t         d;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < COUNT_W / 4; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d == bcd_digit_t'(BCD_MAX)) begin
          d = '0;
        end else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, ce1ms-sampled debouncer and a
// one-cycle press pulse on the debounced level's rising edge.
module btn_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic ce1ms_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEB_MS + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_prev_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= btn_i;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      if (ce1ms_i) begin
        // Any sample agreeing with the stable level restarts the run of differing samples
        if (sync2_q == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(DEB_MS - 1)) begin
          stable_q <= sync2_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign press_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// Start/stop/clear stopwatch counting 000.0 .. 999.9 s in packed BCD.
// Define STOPWATCH_LAP_EN to add the lap-hold display feature on btn_lap.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int DEB_MS  = 20,
  parameter int TICK_MS = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce1ms,
  input  logic               btn_start,
  input  logic               btn_clr,
  input  logic               btn_lap,
  output logic [COUNT_W-1:0] dat,
  output logic               running,
  output logic               ovf
);

  localparam int PW = $clog2(TICK_MS + 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {(COUNT_W / 4){bcd_digit_t'(BCD_MAX)}};

`ifdef STOPWATCH_LAP_EN
  localparam int NUM_BTN = 3;
  logic [NUM_BTN-1:0] btn_raw;
  assign btn_raw = {btn_lap, btn_clr, btn_start};
`else
  localparam int NUM_BTN = 2;
  logic [NUM_BTN-1:0] btn_raw;
  logic               unused_lap;
  assign btn_raw    = {btn_clr, btn_start};
  assign unused_lap = btn_lap;
`endif

  logic [NUM_BTN-1:0] press;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_deb
      btn_debounce #(.DEB_MS(DEB_MS)) u_deb (
        .clk     (clk),
        .rst     (rst),
        .ce1ms_i (ce1ms),
        .btn_i   (btn_raw[gi]),
        .press_o (press[gi])
      );
    end
  endgenerate

  state_t             state_q;
  logic [PW-1:0]      presc_q;
  logic [COUNT_W-1:0] count_q;
  logic               running_q, ovf_q;
  logic               start_ev, clr_to_idle, tick;

  assign start_ev    = press[0];
  // Start beats clear when both fire together
  assign clr_to_idle = (state_q == PAUSE) && press[1] && !start_ev;
  assign tick        = (state_q == RUN) && ce1ms && (presc_q == PW'(TICK_MS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      case (state_q)
        IDLE: begin
          presc_q <= '0;
          if (start_ev) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            presc_q <= '0;
            count_q <= bcd_inc(count_q);
            ovf_q   <= (count_q == COUNT_MAX);
          end else if (ce1ms) begin
            presc_q <= presc_q + PW'(1);
          end
          if (start_ev) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (start_ev) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else if (clr_to_idle) begin
            state_q <= IDLE;
            count_q <= '0;
            presc_q <= '0;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic               hold_q;
  logic [COUNT_W-1:0] lap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 1'b0;
      lap_q  <= '0;
    end else if (clr_to_idle) begin
      hold_q <= 1'b0;
    end else if ((state_q == RUN) && press[2]) begin
      hold_q <= ~hold_q;
      if (!hold_q) lap_q <= count_q;
    end
  end

  assign dat = hold_q ? lap_q : count_q;
`else
  assign dat = count_q;
`endif

  assign running = running_q;
  assign ovf     = ovf_q;

endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 Parameter DEB_MS, default 20: number of consecutive ce1ms samples for a button level to be accepted.
REQ-002 Parameter TICK_MS, default 100: ce1ms pulses per count step (0.1 s).
REQ-003 Port clk  in  1  single system clock; all logic on posedge clk.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port ce1ms  in  1  one-cycle 1 ms enable pulse from the display driver.
REQ-006 Port btn_start  in  1  raw asynchronous start/stop button, active-high.
REQ-007 Port btn_clr  in  1  raw asynchronous clear button, active-high.
REQ-008 Port btn_lap  in  1  raw asynchronous lap button, active-high; present in all builds.
REQ-009 Port dat  out  16  four packed BCD digits: [15:12] hundreds of s, [11:8] tens of s, [7:4] s, [3:0] tenths; feeds the display data input.
REQ-010 Port running  out  1  high while the FSM is in RUN.
REQ-011 Port ovf  out  1  one-cycle pulse when the count wraps 999.9 -> 000.0.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its stable level only after DEB_MS consecutive ce1ms samples differ from it; any sample equal to the stable level SHALL zero the debounce counter.
REQ-013 A press event SHALL be a one-cycle pulse on the stable level's 0->1 transition; releases generate no event.
REQ-014 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-015 Start event: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-016 Clear event: PAUSE->IDLE with the count and prescaler zeroed; ignored in RUN and IDLE.
REQ-017 If start and clear events occur in the same cycle, start SHALL win and clear SHALL be dropped.
REQ-018 The prescaler SHALL count ce1ms only in RUN.
REQ-019 The prescaler SHALL reach TICK_MS-1, then on the next ce1ms issue an internal tick and return to 0.
REQ-020 In PAUSE the prescaler SHALL hold its value; in IDLE it SHALL be 0.
REQ-021 On each tick the BCD count SHALL increment with decimal carry; each digit SHALL range 0-9 only.
REQ-022 On a tick, 9999 SHALL become 0000 with ovf asserted for exactly that cycle, and counting SHALL continue.
REQ-023 dat and ovf SHALL update on the clock edge following the ce1ms cycle that produces the tick (latency one cycle).
REQ-024 running SHALL be a registered decode of state == RUN.

Reset
REQ-025 While rst is high on a clock edge, the following SHALL be cleared:
- state = IDLE
- count = 0000 and dat = 16'h0000
- prescaler = 0
- running = 0, ovf = 0
- synchronizers, debounce counters and stable levels = 0
- lap hold flag cleared
REQ-026 rst asserted mid-RUN SHALL take effect on the same edge, and no tick SHALL be issued on that edge.

Configuration
REQ-027 With macro STOPWATCH_LAP_EN defined, each lap event in RUN SHALL toggle a hold flag:
- hold 0->1 latches the current count into a lap register
- while hold = 1, dat shows the lap register and the live count keeps running
- hold SHALL clear on entry to IDLE
REQ-028 With STOPWATCH_LAP_EN undefined:
- btn_lap is ignored
- no lap logic is synthesized
- dat always equals the live count

Structure
REQ-029 Package stopwatch_pkg SHALL hold:
- state enum (IDLE, RUN, PAUSE)
- 4-bit BCD digit type
- the constants BCD_MAX = 9 and COUNT_W = 16
REQ-030 Debouncing SHALL be the sub-module btn_debounce (synchronizer + debouncer + edge pulse), instantiated once per button.

Verification (DEB_MS = 2, TICK_MS = 3, ce1ms every 4th clk)
REQ-031 2-sample glitch on btn_start: glitch of 1 sample -> no state change; level held for 2 samples -> running = 1, one cycle after the event.
REQ-032 RUN for 30 ce1ms -> dat = 16'h0010; then start -> PAUSE, dat frozen at 0010 and prescaler preserved; start again -> next tick after exactly 3 ce1ms in total.
REQ-033 Preload count to 9999 via run, one tick -> dat = 0000, ovf high for one cycle, running stays 1.
REQ-034 Clear event in RUN -> ignored.
REQ-035 Simultaneous start and clear events in PAUSE -> RUN, count kept.
REQ-036 Clear event in PAUSE -> IDLE, dat = 0000.
REQ-037 rst mid-RUN at dat = 0123 -> next cycle dat = 0000, running = 0, state IDLE.
REQ-038 With STOPWATCH_LAP_EN: lap event at dat = 0042 -> dat holds 0042 while the live count advances; second lap event -> dat shows the live value (e.g. 0047).
